// File: rtl/lobster_dbus_if.sv
// Bus bundle between the lobster CPU requesters (fetch F, load/store D),
// the shared-port arbiter and the single SRAM port.
// The slave modport is the arbiter's view; the master modport is the
// view of whatever drives the requests and models the SRAM.
interface lobster_dbus_if #(
   parameter int ADDR_WIDTH = 36
);
   // fetch requester
   logic                  f_req;
   logic [ADDR_WIDTH-1:0] f_addr;
   logic                  f_ack;
   logic [63:0]           f_rdata;
   logic                  f_err;

   // load/store requester
   logic                  d_req;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [63:0]           d_wdata;
   logic                  d_ack;
   logic [63:0]           d_rdata;
   logic                  d_err;

   // SRAM port
   logic                  mem_ce;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr_in;
   logic [ADDR_WIDTH-1:0] mem_addr_out;
   logic [63:0]           mem_data_out;
   logic [63:0]           mem_data_in;
   logic                  mem_rdy;

   // status
   logic                  busy;

   modport slave (
      input  f_req, f_addr,
      output f_ack, f_rdata, f_err,
      input  d_req, d_we, d_addr, d_wdata,
      output d_ack, d_rdata, d_err,
      output mem_ce, mem_we, mem_addr_in, mem_addr_out, mem_data_out,
      input  mem_data_in, mem_rdy,
      output busy
   );

   modport master (
      output f_req, f_addr,
      input  f_ack, f_rdata, f_err,
      output d_req, d_we, d_addr, d_wdata,
      input  d_ack, d_rdata, d_err,
      input  mem_ce, mem_we, mem_addr_in, mem_addr_out, mem_data_out,
      output mem_data_in, mem_rdy,
      input  busy
   );
endinterface

// File: rtl/lobster_dbus_arbiter.sv
// Shares the single SRAM port between the fetch (F) and load/store (D)
// requesters. Round-robin between the two, one transaction in flight at a
// time, and a BUSY-cycle timeout that completes the transaction with an
// error rather than stalling the pipeline forever.
module lobster_dbus_arbiter #(
   parameter int ADDR_WIDTH = 36,
   parameter int TIMEOUT    = 255
) (
   input  logic          clk,
   input  logic          rst,
   lobster_dbus_if.slave bus
);

   // Counter only has to reach TIMEOUT-1; it is cleared on every grant.
   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic {IDLE, BUSY}   state_t;
   typedef enum logic {OWN_F, OWN_D} owner_t;

   state_t                state;
   owner_t                owner;
   owner_t                last_grant;
   owner_t                grant_sel;
   logic                  any_req;
   logic [CNT_W-1:0]      cnt;
   logic                  cmd_we;

   logic                  f_ack_r;
   logic [63:0]           f_rdata_r;
   logic                  f_err_r;
   logic                  d_ack_r;
   logic [63:0]           d_rdata_r;
   logic                  d_err_r;
   logic                  mem_ce_r;
   logic                  mem_we_r;
   logic [ADDR_WIDTH-1:0] mem_addr_r;
   logic [63:0]           mem_wdata_r;
   logic                  busy_r;

   // Arbitration: a lone request wins outright; on a tie the requester that
   // was not granted last time wins.
   always_comb begin
      any_req   = bus.f_req | bus.d_req;
      grant_sel = OWN_F;
      if (bus.f_req && bus.d_req) begin
         grant_sel = (last_grant == OWN_D) ? OWN_F : OWN_D;
      end else if (bus.d_req) begin
         grant_sel = OWN_D;
      end
   end

   // Transaction FSM; every output is a register so the SRAM and the
   // pipeline see glitch-free, cycle-aligned strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= OWN_F;
         last_grant  <= OWN_D;
         cnt         <= '0;
         cmd_we      <= 1'b0;
         f_ack_r     <= 1'b0;
         f_rdata_r   <= '0;
         f_err_r     <= 1'b0;
         d_ack_r     <= 1'b0;
         d_rdata_r   <= '0;
         d_err_r     <= 1'b0;
         mem_ce_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         busy_r      <= 1'b0;
      end else begin
         // acks are single-cycle pulses; data/err only meaningful with them
         f_ack_r   <= 1'b0;
         f_rdata_r <= '0;
         f_err_r   <= 1'b0;
         d_ack_r   <= 1'b0;
         d_rdata_r <= '0;
         d_err_r   <= 1'b0;

         case (state)
            IDLE: begin
               if (any_req) begin
                  owner      <= grant_sel;
                  last_grant <= grant_sel;
                  cnt        <= '0;
                  mem_ce_r   <= 1'b1;
                  busy_r     <= 1'b1;
                  state      <= BUSY;
                  if (grant_sel == OWN_D) begin
                     cmd_we      <= bus.d_we;
                     mem_we_r    <= bus.d_we;
                     mem_addr_r  <= bus.d_addr;
                     mem_wdata_r <= bus.d_wdata;
                  end else begin
                     // fetches are always reads
                     cmd_we      <= 1'b0;
                     mem_we_r    <= 1'b0;
                     mem_addr_r  <= bus.f_addr;
                     mem_wdata_r <= '0;
                  end
               end
            end

            BUSY: begin
               // mem_rdy wins over a timeout landing in the same cycle
               if (bus.mem_rdy || (cnt == CNT_LAST)) begin
                  mem_ce_r <= 1'b0;
                  mem_we_r <= 1'b0;
                  busy_r   <= 1'b0;
                  state    <= IDLE;
                  if (owner == OWN_F) begin
                     f_ack_r   <= 1'b1;
                     f_err_r   <= ~bus.mem_rdy;
                     f_rdata_r <= bus.mem_rdy ? bus.mem_data_in : 64'd0;
                  end else begin
                     d_ack_r   <= 1'b1;
                     d_err_r   <= ~bus.mem_rdy;
                     d_rdata_r <= (bus.mem_rdy && !cmd_we) ? bus.mem_data_in : 64'd0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.f_ack        = f_ack_r;
   assign bus.f_rdata      = f_rdata_r;
   assign bus.f_err        = f_err_r;
   assign bus.d_ack        = d_ack_r;
   assign bus.d_rdata      = d_rdata_r;
   assign bus.d_err        = d_err_r;
   assign bus.mem_ce       = mem_ce_r;
   assign bus.mem_we       = mem_we_r;
   assign bus.mem_addr_in  = mem_addr_r;
   assign bus.mem_addr_out = mem_addr_r;
   assign bus.mem_data_out = mem_wdata_r;
   assign bus.busy         = busy_r;

endmodule

// File: tb/tb_lobster_dbus_arbiter.sv
// Directed bench for lobster_dbus_arbiter (TIMEOUT=4 so the abort path is short).
module tb_lobster_dbus_arbiter;

   localparam int AW = 36;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   lobster_dbus_if #(.ADDR_WIDTH(AW)) bus_if ();

   lobster_dbus_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // one comparison: tag, observed, expected
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // inputs change and outputs are sampled on the falling edge
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus_if.f_req       = 1'b0;
      bus_if.f_addr      = '0;
      bus_if.d_req       = 1'b0;
      bus_if.d_we        = 1'b0;
      bus_if.d_addr      = '0;
      bus_if.d_wdata     = '0;
      bus_if.mem_rdy     = 1'b0;
      bus_if.mem_data_in = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      logic [AW-1:0] exp_addr;
      idle_inputs();

      // reset with both requests held: nothing may start
      rst = 1'b1;
      bus_if.f_req = 1'b1;
      bus_if.d_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_ce",    64'(bus_if.mem_ce), 64'd0);
         chk("rst_acks",  64'({bus_if.f_ack, bus_if.d_ack, bus_if.f_err, bus_if.d_err}), 64'd0);
         chk("rst_busy",  64'(bus_if.busy), 64'd0);
         chk("rst_data",  64'(bus_if.f_rdata | bus_if.d_rdata | bus_if.mem_data_out), 64'd0);
      end
      idle_inputs();
      rst = 1'b0;
      tick();
      chk("idle_ce", 64'(bus_if.mem_ce), 64'd0);

      // mem_rdy while idle is ignored
      bus_if.mem_rdy = 1'b1;
      tick();
      chk("idle_rdy_ack", 64'({bus_if.f_ack, bus_if.d_ack}), 64'd0);
      chk("idle_rdy_ce",  64'(bus_if.mem_ce), 64'd0);
      bus_if.mem_rdy = 1'b0;

      // fetch read, mem_rdy two cycles after mem_ce rises
      bus_if.f_req  = 1'b1;
      bus_if.f_addr = 36'hF800;
      tick();
      chk("f_ce",   64'(bus_if.mem_ce), 64'd1);
      chk("f_addr", 64'(bus_if.mem_addr_in), 64'hF800);
      chk("f_we",   64'(bus_if.mem_we), 64'd0);
      chk("f_busy", 64'(bus_if.busy), 64'd1);
      tick();
      chk("f_hold_ce",  64'(bus_if.mem_ce), 64'd1);
      chk("f_no_ack",   64'(bus_if.f_ack), 64'd0);
      bus_if.mem_rdy     = 1'b1;
      bus_if.mem_data_in = 64'h1234;
      tick();
      chk("f_ack",   64'(bus_if.f_ack), 64'd1);
      chk("f_rdata", bus_if.f_rdata, 64'h1234);
      chk("f_err",   64'(bus_if.f_err), 64'd0);
      chk("f_d_ack", 64'(bus_if.d_ack), 64'd0);
      chk("f_ce_off", 64'(bus_if.mem_ce), 64'd0);
      idle_inputs();
      tick();
      chk("f_ack_pulse", 64'(bus_if.f_ack), 64'd0);

      // store: mem_we / write address / write data held until mem_rdy
      bus_if.d_req   = 1'b1;
      bus_if.d_we    = 1'b1;
      bus_if.d_addr  = 36'h100;
      bus_if.d_wdata = 64'hDEAD;
      tick();
      for (int i = 0; i < 2; i++) begin
         chk("st_we",    64'(bus_if.mem_we), 64'd1);
         chk("st_waddr", 64'(bus_if.mem_addr_out), 64'h100);
         chk("st_raddr", 64'(bus_if.mem_addr_in), 64'h100);
         chk("st_wdata", bus_if.mem_data_out, 64'hDEAD);
         // requester inputs are ignored while busy
         bus_if.d_wdata = 64'hBEEF;
         if (i == 1) begin
            bus_if.mem_rdy     = 1'b1;
            bus_if.mem_data_in = 64'h5555;
         end
         tick();
      end
      chk("st_ack",   64'(bus_if.d_ack), 64'd1);
      chk("st_rdata", bus_if.d_rdata, 64'd0);
      chk("st_err",   64'(bus_if.d_err), 64'd0);
      chk("st_we_off", 64'(bus_if.mem_we), 64'd0);
      idle_inputs();
      tick();

      // both requests held from reset: F,D,F,D with correct routing
      rst = 1'b1;
      bus_if.f_req  = 1'b1;
      bus_if.f_addr = 36'hA0;
      bus_if.d_req  = 1'b1;
      bus_if.d_addr = 36'hB0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_addr = (i % 2 == 0) ? 36'hA0 : 36'hB0;
         chk("rr_grant", 64'(bus_if.mem_addr_in), 64'(exp_addr));
         bus_if.mem_rdy     = 1'b1;
         bus_if.mem_data_in = 64'h700 + 64'(i);
         tick();
         bus_if.mem_rdy = 1'b0;
         chk("rr_acks", 64'({bus_if.f_ack, bus_if.d_ack}), (i % 2 == 0) ? 64'd2 : 64'd1);
         chk("rr_data", (i % 2 == 0) ? bus_if.f_rdata : bus_if.d_rdata, 64'h700 + 64'(i));
      end
      idle_inputs();
      tick();

      // timeout: mem_ce high for 4 cycles, then error ack
      bus_if.d_req       = 1'b1;
      bus_if.d_addr      = 36'h200;
      bus_if.mem_data_in = 64'hCAFE;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("to_ce",     64'(bus_if.mem_ce), 64'd1);
         chk("to_no_ack", 64'(bus_if.d_ack), 64'd0);
      end
      tick();
      chk("to_ack",   64'(bus_if.d_ack), 64'd1);
      chk("to_err",   64'(bus_if.d_err), 64'd1);
      chk("to_rdata", bus_if.d_rdata, 64'd0);
      chk("to_ce_off", 64'(bus_if.mem_ce), 64'd0);
      idle_inputs();

      // fetch after the timeout, mem_rdy exactly in the last allowed cycle
      bus_if.f_req  = 1'b1;
      bus_if.f_addr = 36'h300;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("edge_ce", 64'(bus_if.mem_ce), 64'd1);
      end
      bus_if.mem_rdy     = 1'b1;
      bus_if.mem_data_in = 64'h4242;
      tick();
      chk("edge_ack",   64'(bus_if.f_ack), 64'd1);
      chk("edge_err",   64'(bus_if.f_err), 64'd0);
      chk("edge_rdata", bus_if.f_rdata, 64'h4242);
      idle_inputs();
      tick();

      // reset while busy: transaction dropped, request re-served afterwards
      bus_if.f_req  = 1'b1;
      bus_if.f_addr = 36'h400;
      tick();
      chk("rb_ce", 64'(bus_if.mem_ce), 64'd1);
      rst = 1'b1;
      bus_if.mem_rdy = 1'b1;
      tick();
      chk("rb_ce_off", 64'(bus_if.mem_ce), 64'd0);
      chk("rb_no_ack", 64'({bus_if.f_ack, bus_if.d_ack}), 64'd0);
      rst = 1'b0;
      bus_if.mem_rdy = 1'b0;
      tick();
      chk("rb_regrant", 64'(bus_if.mem_addr_in), 64'h400);
      bus_if.mem_rdy     = 1'b1;
      bus_if.mem_data_in = 64'h99;
      tick();
      chk("rb_ack",   64'(bus_if.f_ack), 64'd1);
      chk("rb_rdata", bus_if.f_rdata, 64'h99);
      idle_inputs();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
